// File: rtl/mnist_pkg.sv
// ---------------------------------------------------------------------------
// mnist_pkg
// Shared constants for the MNIST classifier datapath (mac_acc, mnist_argmax
// and the result readout), plus the state encoding of the argmax stage.
//   NUM_CLASSES : scores per frame (one per digit)
//   SCORE_W     : signed score width produced by mac_acc
//   IDX_W       : class index width, 2**IDX_W >= NUM_CLASSES
// ---------------------------------------------------------------------------
package mnist_pkg;

   localparam int NUM_CLASSES = 10;
   localparam int SCORE_W     = 22;
   localparam int IDX_W       = 4;

   // Plain 2-bit constants keep the encoding readable in older tools and
   // in waveform viewers that do not decode enums.
   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_COLLECT = 2'd1;
   localparam state_t ST_DONE    = 2'd2;

endpackage : mnist_pkg

// File: rtl/score_max_sel.sv
// ---------------------------------------------------------------------------
// score_max_sel
// Combinational signed compare/select for the running maximum. The incoming
// score replaces the current best only when it is strictly greater, so on a
// tie the earlier (lower) class index is kept.
//   i_din        : incoming signed score
//   i_cnt        : index of the incoming score within the frame
//   i_best_score : current best score
//   i_best_idx   : index of the current best score
//   o_best_score : best score after considering i_din
//   o_best_idx   : index of o_best_score
// ---------------------------------------------------------------------------
module score_max_sel #(
   parameter int SCORE_W = 22,
   parameter int IDX_W   = 4
) (
   input  logic signed [SCORE_W-1:0] i_din,
   input  logic        [IDX_W-1:0]   i_cnt,
   input  logic signed [SCORE_W-1:0] i_best_score,
   input  logic        [IDX_W-1:0]   i_best_idx,
   output logic signed [SCORE_W-1:0] o_best_score,
   output logic        [IDX_W-1:0]   o_best_idx
);

   always_comb begin
      // NOTE: defaults first so every path assigns every output; otherwise
      // the missing else branch would infer a latch.
      o_best_score = i_best_score;
      o_best_idx   = i_best_idx;
      if (i_din > i_best_score) begin
         o_best_score = i_din;
         o_best_idx   = i_cnt;
      end
   end

endmodule : score_max_sel

// File: rtl/mnist_argmax.sv
// ---------------------------------------------------------------------------
// mnist_argmax
// Classifier output stage: consumes one signed score per class from mac_acc
// and reports the winning class index and its score via valid/ready.
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-high reset
//   din        : signed score from mac_acc
//   din_valid  : din is valid this cycle
//   din_ready  : stage can accept a score (low only while a result waits)
//   class_idx  : winning class, valid while out_valid
//   max_score  : winning score, signed
//   out_valid  : result available, held until accepted
//   out_ready  : consumer accepts the result
// ---------------------------------------------------------------------------
module mnist_argmax #(
   parameter int NUM_CLASSES = mnist_pkg::NUM_CLASSES,
   parameter int SCORE_W     = mnist_pkg::SCORE_W,
   parameter int IDX_W       = mnist_pkg::IDX_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SCORE_W-1:0] din,
   input  logic               din_valid,
   output logic               din_ready,
   output logic [IDX_W-1:0]   class_idx,
   output logic [SCORE_W-1:0] max_score,
   output logic               out_valid,
   input  logic               out_ready
);

   import mnist_pkg::*;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   state_t                    r_state;
   logic        [IDX_W-1:0]   r_cnt;
   logic signed [SCORE_W-1:0] r_best_score;
   logic        [IDX_W-1:0]   r_best_idx;

   logic                      w_accept;
   logic signed [SCORE_W-1:0] w_next_score;
   logic        [IDX_W-1:0]   w_next_idx;

   assign din_ready = (r_state != ST_DONE);
   assign w_accept  = din_valid && din_ready;

   score_max_sel #(
      .SCORE_W (SCORE_W),
      .IDX_W   (IDX_W)
   ) u_sel (
      .i_din        ($signed(din)),
      .i_cnt        (r_cnt),
      .i_best_score (r_best_score),
      .i_best_idx   (r_best_idx),
      .o_best_score (w_next_score),
      .o_best_idx   (w_next_idx)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_best_score <= '0;
         r_best_idx   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // First score of a frame is loaded unconditionally so that
               // all-negative frames never lose to the reset value of zero.
               if (w_accept) begin
                  r_best_score <= $signed(din);
                  r_best_idx   <= '0;
                  if (NUM_CLASSES == 1) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_cnt   <= IDX_W'(1);
                     r_state <= ST_COLLECT;
                  end
               end
            end

            ST_COLLECT: begin
               if (w_accept) begin
                  r_best_score <= w_next_score;
                  r_best_idx   <= w_next_idx;
                  // cnt stops at the last index instead of wrapping; it is
                  // cleared when the result leaves.
                  if (r_cnt == LAST_IDX) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_cnt <= r_cnt + IDX_W'(1);
                  end
               end
            end

            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Best registers are frozen in DONE (no accept possible), so the result
   // is stable for the whole output handshake.
   assign out_valid = (r_state == ST_DONE);
   assign class_idx = r_best_idx;
   assign max_score = r_best_score;

endmodule : mnist_argmax

// File: tb/tb_mnist_argmax.sv
// ---------------------------------------------------------------------------
// tb_mnist_argmax
// Directed self-checking bench for mnist_argmax with hand-computed results.
// ---------------------------------------------------------------------------
module tb_mnist_argmax;

   localparam int NUM_CLASSES = 10;
   localparam int SCORE_W     = 22;
   localparam int IDX_W       = 4;

   logic               clk;
   logic               rst;
   logic [SCORE_W-1:0] din;
   logic               din_valid;
   logic               din_ready;
   logic [IDX_W-1:0]   class_idx;
   logic [SCORE_W-1:0] max_score;
   logic               out_valid;
   logic               out_ready;

   int n_checks;
   int n_fails;

   mnist_argmax #(
      .NUM_CLASSES (NUM_CLASSES),
      .SCORE_W     (SCORE_W),
      .IDX_W       (IDX_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .class_idx (class_idx),
      .max_score (max_score),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int score_i();
      return int'($signed(max_score));
   endfunction

   // Presents n scores, one accept per call step, with `gap` idle cycles in
   // between. Inputs change 1 time unit after a rising edge; outputs are
   // sampled at the same point. While the frame is incomplete out_valid
   // must stay low.
   task automatic send_scores(input string tag, input int s[10], input int n,
                              input int gap, input bit completes);
      for (int i = 0; i < n; i++) begin
         din       = SCORE_W'(s[i]);
         din_valid = 1'b1;
         @(posedge clk);
         #1;
         din_valid = 1'b0;
         if (!(completes && i == n - 1)) begin
            check({tag, "_mid_valid"}, int'(out_valid), 0);
            for (int g = 0; g < gap; g++) begin
               @(posedge clk);
               #1;
               check({tag, "_gap_valid"}, int'(out_valid), 0);
            end
         end
      end
   endtask

   // Called right after the accepting edge of the last score with
   // out_ready high: result visible now, gone one cycle later.
   task automatic expect_result(input string tag, input int idx, input int score);
      check({tag, "_valid"}, int'(out_valid), 1);
      check({tag, "_idx"},   int'(class_idx), idx);
      check({tag, "_score"}, score_i(),       score);
      @(posedge clk);
      #1;
      check({tag, "_valid_drop"}, int'(out_valid), 0);
      check({tag, "_ready_back"}, int'(din_ready), 1);
   endtask

   int basic[10];
   int tie[10];
   int neg[10];
   int ext[10];
   int bp[10];
   int tail9[10];
   int abrt[10];
   int rfr[10];

   initial begin
      n_checks  = 0;
      n_fails   = 0;
      rst       = 1'b1;
      din       = '0;
      din_valid = 1'b0;
      out_ready = 1'b1;

      basic = '{5, -3, 12, 0, 7, 100, 99, -50, 8, 1};
      tie   = '{1, 2, 40, 3, 4, 5, 40, 6, 7, 8};
      neg   = '{-100, -99, -98, -97, -96, -95, -94, -93, -92, -91};
      for (int i = 0; i < 10; i++) ext[i] = -2097152;
      bp    = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
      tail9 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
      abrt  = '{500, 500, 500, 500, 0, 0, 0, 0, 0, 0};
      rfr   = '{1, 2, 3, 50, 4, 5, 6, 7, 8, 9};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_din_ready", int'(din_ready), 1);
      check("rst_class_idx", int'(class_idx), 0);
      check("rst_max_score", score_i(),       0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Back-to-back frames, out_ready held high the whole time
      send_scores("basic", basic, 10, 0, 1'b1);
      expect_result("basic", 5, 100);
      send_scores("tie", tie, 10, 0, 1'b1);
      expect_result("tie", 2, 40);
      send_scores("neg", neg, 10, 0, 1'b1);
      expect_result("neg", 9, -91);
      send_scores("ext", ext, 10, 0, 1'b1);
      expect_result("ext", 0, -2097152);

      // mac_acc cadence: one valid in four cycles
      send_scores("gap", basic, 10, 3, 1'b1);
      expect_result("gap", 5, 100);

      // Backpressure with the next frame's first score waiting
      out_ready = 1'b0;
      send_scores("bp", bp, 10, 0, 1'b1);
      din       = SCORE_W'(77);
      din_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         check("bp_hold_valid", int'(out_valid), 1);
         check("bp_hold_idx",   int'(class_idx), 5);
         check("bp_hold_score", score_i(),       9);
         check("bp_hold_ready", int'(din_ready), 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_xfer_valid", int'(out_valid), 0);
      check("bp_xfer_ready", int'(din_ready), 1);
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      send_scores("bp_next", tail9, 9, 0, 1'b1);
      expect_result("bp_next", 0, 77);

      // Reset mid-frame discards the partial frame
      send_scores("abort", abrt, 4, 0, 1'b0);
      rst = 1'b1;
      #1;
      check("abort_rst_valid", int'(out_valid), 0);
      check("abort_rst_ready", int'(din_ready), 1);
      check("abort_rst_idx",   int'(class_idx), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_scores("refr", rfr, 10, 0, 1'b1);
      expect_result("refr", 3, 50);

      // Reset while a result is waiting drops it
      out_ready = 1'b0;
      send_scores("drop", basic, 10, 0, 1'b1);
      check("drop_pre_valid", int'(out_valid), 1);
      rst = 1'b1;
      #1;
      check("drop_rst_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("drop_post_valid", int'(out_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_mnist_argmax
